// File: rtl/transmitter_pkg.sv
// Shared UART definitions: one-hot transmitter states, default frame sizing,
// parity-mode constants and the parity helper.
package transmitter_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } tx_state_e;

  localparam int DEF_NB_DATA = 8;
  localparam int DEF_N_TICKS = 16;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Parity bit for a word (zero-extended to 32 bits, which leaves the parity unchanged).
  function automatic logic word_parity(input logic [31:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/transmitter.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, optional parity,
// one stop bit, with a one-entry holding register for back-to-back frames.
module transmitter
  import transmitter_pkg::*;
#(
  parameter int NB_DATA    = DEF_NB_DATA,
  parameter int N_TICKS    = DEF_N_TICKS,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = PAR_EVEN
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_signal_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_ready,
  output logic               o_busy,
  output logic               o_tx_done
);

  localparam int TW = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
  localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(N_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

  tx_state_e          state_r, state_nx;
  logic [TW-1:0]      tick_cnt_r, tick_cnt_nx;
  logic [BW-1:0]      bit_cnt_r, bit_cnt_nx;
  logic [NB_DATA-1:0] shift_r, shift_nx;
  logic [NB_DATA-1:0] hold_data_r, hold_data_nx;
  logic               hold_valid_r, hold_valid_nx;
  logic               parity_r, parity_nx;
  logic               tx_r, tx_nx;
  logic               done_r, done_nx;
  logic               ready_r, busy_r;
  logic               accept_s, bit_end_s;

  // Next-state, holding-register and serial-line logic.
  always_comb begin
    accept_s      = i_tx_start && ready_r;
    bit_end_s     = i_signal_tick && (tick_cnt_r == TICK_LAST);
    state_nx      = state_r;
    bit_cnt_nx    = bit_cnt_r;
    shift_nx      = shift_r;
    parity_nx     = parity_r;
    tx_nx         = tx_r;
    done_nx       = 1'b0;
    // Accept and load are mutually exclusive: accept needs an empty holding register.
    if (accept_s) begin
      hold_data_nx  = i_data;
      hold_valid_nx = 1'b1;
    end else begin
      hold_data_nx  = hold_data_r;
      hold_valid_nx = hold_valid_r;
    end
    if ((state_r != ST_IDLE) && i_signal_tick) begin
      tick_cnt_nx = bit_end_s ? '0 : tick_cnt_r + TW'(1);
    end else begin
      tick_cnt_nx = tick_cnt_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (hold_valid_r) begin
          state_nx      = ST_START;
          shift_nx      = hold_data_r;
          parity_nx     = word_parity(32'(hold_data_r), PARITY_ODD != 0);
          hold_valid_nx = 1'b0;
          tick_cnt_nx   = '0;
          tx_nx         = 1'b0;
        end else begin
          tick_cnt_nx = '0;
          tx_nx       = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_nx   = ST_DATA;
          bit_cnt_nx = '0;
          tx_nx      = shift_r[0];
        end else begin
          tx_nx = 1'b0;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shift_nx = shift_r >> 1;
          if (bit_cnt_r == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              state_nx = ST_PARITY;
              tx_nx    = parity_r;
            end else begin
              state_nx = ST_STOP;
              tx_nx    = 1'b1;
            end
          end else begin
            bit_cnt_nx = bit_cnt_r + BW'(1);
            tx_nx      = shift_r[1];
          end
        end else begin
          tx_nx = shift_r[0];
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_nx = ST_STOP;
          tx_nx    = 1'b1;
        end else begin
          tx_nx = parity_r;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          done_nx = 1'b1;
          // A queued word starts on this same edge, so frames abut with no idle gap.
          if (hold_valid_r) begin
            state_nx      = ST_START;
            shift_nx      = hold_data_r;
            parity_nx     = word_parity(32'(hold_data_r), PARITY_ODD != 0);
            hold_valid_nx = 1'b0;
            tick_cnt_nx   = '0;
            tx_nx         = 1'b0;
          end else begin
            state_nx = ST_IDLE;
            tx_nx    = 1'b1;
          end
        end else begin
          tx_nx = 1'b1;
        end
      end
      default: begin
        state_nx    = ST_IDLE;
        tx_nx       = 1'b1;
        tick_cnt_nx = '0;
        bit_cnt_nx  = '0;
      end
    endcase
  end

  // State and datapath registers; every output is taken straight from a flop.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r      <= ST_IDLE;
      tick_cnt_r   <= '0;
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      hold_data_r  <= '0;
      hold_valid_r <= 1'b0;
      parity_r     <= 1'b0;
      tx_r         <= 1'b1;
      done_r       <= 1'b0;
      ready_r      <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nx;
      tick_cnt_r   <= tick_cnt_nx;
      bit_cnt_r    <= bit_cnt_nx;
      shift_r      <= shift_nx;
      hold_data_r  <= hold_data_nx;
      hold_valid_r <= hold_valid_nx;
      parity_r     <= parity_nx;
      tx_r         <= tx_nx;
      done_r       <= done_nx;
      ready_r      <= ~hold_valid_nx;
      busy_r       <= (state_nx != ST_IDLE);
    end
  end

  assign o_tx       = tx_r;
  assign o_tx_ready = ready_r;
  assign o_busy     = busy_r;
  assign o_tx_done  = done_r;

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for transmitter: three instances (no parity, even, odd) share
// clock, reset, tick and data; a tick-counting monitor reconstructs each frame.
module tb_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] data = 8'h00;
  logic [2:0] start = 3'b000;
  logic [2:0] tx, ready, busy, done;

  always #5 clk = ~clk;

  transmitter #(.NB_DATA(8), .N_TICKS(16), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .i_clock(clk), .i_reset(rst), .i_signal_tick(tick), .i_tx_start(start[0]), .i_data(data),
    .o_tx(tx[0]), .o_tx_ready(ready[0]), .o_busy(busy[0]), .o_tx_done(done[0]));
  transmitter #(.NB_DATA(8), .N_TICKS(16), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .i_clock(clk), .i_reset(rst), .i_signal_tick(tick), .i_tx_start(start[1]), .i_data(data),
    .o_tx(tx[1]), .o_tx_ready(ready[1]), .o_busy(busy[1]), .o_tx_done(done[1]));
  transmitter #(.NB_DATA(8), .N_TICKS(16), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .i_clock(clk), .i_reset(rst), .i_signal_tick(tick), .i_tx_start(start[2]), .i_data(data),
    .o_tx(tx[2]), .o_tx_ready(ready[2]), .o_busy(busy[2]), .o_tx_done(done[2]));

  int tp = 4;
  int tdiv = 0;
  int total = 0;
  int bad = 0;
  int done_cnt[3] = '{0, 0, 0};
  int busy_ticks[3] = '{0, 0, 0};
  int idle_seen = 0;
  bit watch_idle = 1'b0;

  // Tick every tp clocks, changed just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (tdiv >= tp - 1) begin
      tdiv = 0;
      tick = 1'b1;
    end else begin
      tdiv = tdiv + 1;
      tick = 1'b0;
    end
  end

  // Counts done pulses and ticks consumed while busy (tick and busy seen together here).
  always @(negedge clk) begin
    if (!rst) begin
      for (int u = 0; u < 3; u++) begin
        done_cnt[u] += int'(done[u]);
        busy_ticks[u] += int'(busy[u] && tick);
      end
      if (watch_idle && !busy[0]) idle_seen++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input int u, input logic [7:0] d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (ready[u]) begin
        data = d;
        start[u] = 1'b1;
        ok = 1'b1;
      end
    end
    @(negedge clk);
    start[u] = 1'b0;
  endtask

  task automatic wait_fall(input int u, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (tx[u] === 1'b0) ok = 1'b1;
    end
  endtask

  // Samples bit i at the 8th tick consumed inside it, starting from the falling start edge.
  task automatic capture(input int u, input int nbits, output logic [10:0] frame, output bit ok);
    bit fell;
    bit pending;
    int consumed;
    int idx;
    frame = '0;
    wait_fall(u, fell);
    ok = 1'b0;
    if (fell) begin
      pending = tick;
      consumed = 0;
      idx = 1;
      for (int g = 0; g < 20000 && idx < nbits; g++) begin
        @(negedge clk);
        if (pending) begin
          consumed++;
          if (consumed == 16 * idx + 8) begin
            frame[idx] = tx[u];
            idx++;
          end
        end
        pending = tick;
      end
      ok = (idx == nbits);
    end
  endtask

  task automatic wait_ticks(input int n);
    bit pending;
    int consumed;
    pending = tick;
    consumed = 0;
    for (int g = 0; g < 20000 && consumed < n; g++) begin
      @(negedge clk);
      if (pending) consumed++;
      pending = tick;
    end
  endtask

  task automatic wait_idle(input int u);
    for (int g = 0; g < 20000 && busy[u]; g++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    int          unit;
    logic [7:0]  data;
    int          len;
    logic [10:0] frame;  // bit i = i-th bit on the wire
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit ok, ok2;
    logic [10:0] f1, f2;
    int d0, t0;
    logic [7:0] rb;

    vecs[0] = '{0, 8'hA5, 10, 11'h34A};
    vecs[1] = '{0, 8'h00, 10, 11'h200};
    vecs[2] = '{0, 8'hFF, 10, 11'h3FE};
    vecs[3] = '{0, 8'h3C, 10, 11'h278};
    vecs[4] = '{1, 8'h07, 11, 11'h60E};
    vecs[5] = '{2, 8'h07, 11, 11'h40E};
    vecs[6] = '{1, 8'h81, 11, 11'h502};
    vecs[7] = '{2, 8'h81, 11, 11'h702};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tx", {29'd0, tx}, 32'h7);
    check("reset ready", {29'd0, ready}, 32'h7);
    check("reset busy", {29'd0, busy}, 32'h0);
    check("reset done", {29'd0, done}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle tick ignored", {29'd0, busy}, 32'h0);

    foreach (vecs[i]) begin
      d0 = done_cnt[vecs[i].unit];
      t0 = busy_ticks[vecs[i].unit];
      send(vecs[i].unit, vecs[i].data, ok);
      check($sformatf("accept[%0d]", i), {31'd0, ok}, 32'd1);
      capture(vecs[i].unit, vecs[i].len, f1, ok);
      check($sformatf("frame[%0d]", i), {20'd0, ok, f1}, {20'd0, 1'b1, vecs[i].frame});
      wait_idle(vecs[i].unit);
      check($sformatf("done[%0d]", i), 32'(done_cnt[vecs[i].unit] - d0), 32'd1);
      check($sformatf("ticks[%0d]", i), 32'(busy_ticks[vecs[i].unit] - t0), 32'(vecs[i].len * 16));
    end

    // Back-to-back 0x3C, 0xC3 with a third request held while the holding register is full.
    d0 = done_cnt[0];
    t0 = busy_ticks[0];
    fork
      begin
        capture(0, 10, f1, ok);
        idle_seen = 0;
        watch_idle = 1'b1;
        capture(0, 10, f2, ok2);
        watch_idle = 1'b0;
      end
      begin
        send(0, 8'h3C, ok);
        send(0, 8'hC3, ok);
        @(negedge clk);
        data = 8'h55;
        start[0] = 1'b1;
        check("full not ready", {31'd0, ready[0]}, 32'd0);
        repeat (100) @(negedge clk);
        start[0] = 1'b0;
      end
    join
    check("b2b frame1", {20'd0, ok, f1}, {20'd0, 1'b1, 11'h278});
    check("b2b frame2", {20'd0, ok2, f2}, {20'd0, 1'b1, 11'h386});
    check("b2b no gap", 32'(idle_seen), 32'd0);
    wait_idle(0);
    repeat (200) @(negedge clk);
    check("b2b done count", 32'(done_cnt[0] - d0), 32'd2);
    check("b2b ticks", 32'(busy_ticks[0] - t0), 32'd320);
    check("third dropped", {30'd0, busy[0], tx[0]}, 32'd1);

    // Reset in the middle of data bit 3.
    d0 = done_cnt[0];
    send(0, 8'hA5, ok);
    wait_fall(0, ok);
    wait_ticks(16 * 4 + 8);
    check("pre-reset bit3", {31'd0, tx[0]}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid reset tx/busy/ready", {29'd0, tx[0], busy[0], ready[0]}, 32'b101);
    repeat (300) @(negedge clk);
    check("mid reset no done", 32'(done_cnt[0] - d0), 32'd0);
    send(0, 8'h5A, ok);
    capture(0, 10, f1, ok);
    check("post reset frame", {20'd0, ok, f1}, {20'd0, 1'b1, 11'h2B4});
    wait_idle(0);

    // Random bytes with a tick on every clock.
    tp = 1;
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      send(0, rb, ok);
      capture(0, 10, f1, ok);
      check($sformatf("random[%0d]", i), {20'd0, ok, f1}, {20'd0, 1'b1, 1'b0, 1'b1, rb, 1'b0});
      wait_idle(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
